// File: rtl/mc_ctrl_fsm.sv
// Multicycle control FSM for the RV32I datapath.
// Sequences FETCH/DECODE/EXEC/MEM/WB, drives datapath strobes and mux
// selects, handshakes with a single shared memory over req/ready and
// traps on unsupported opcodes or memory timeouts.
// Optional: define MC_INSTRET_EN to add the 32-bit retired-instruction
// counter output 'instret'.
//
// state  | meaning
// -------+--------------------------------------------------------------
// IDLE   | one cycle after reset before the first fetch
// FETCH  | instruction read from PC address, ir_we on mem_ready
// DECODE | classify opcode into the class register
// EXEC   | ALU operation, branch/jump PC update and link write
// MEM    | data access at ALU address (load or store)
// WB     | register write-back and PC+4 update
// FAULT  | trap: all strobes off, left only by reset
module mc_ctrl_fsm #(
    parameter int TIMEOUT   = 255,
    parameter int TIMEOUT_W = 8
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [6:0] opcode,
    input  logic       branch_taken,
    input  logic       mem_ready,
    output logic       mem_req,
    output logic       mem_we,
    output logic       mem_sel_data,
    output logic       ir_we,
    output logic       pc_we,
    output logic [1:0] pc_src,
    output logic       alu_src_b,
    output logic [1:0] alu_op,
    output logic       rf_we,
    output logic [1:0] wb_sel,
    output logic       fault,
    output logic [2:0] state
`ifdef MC_INSTRET_EN
    ,
    output logic [31:0] instret
`endif
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_FETCH  = 3'd1,
        S_DECODE = 3'd2,
        S_EXEC   = 3'd3,
        S_MEM    = 3'd4,
        S_WB     = 3'd5,
        S_FAULT  = 3'd6
    } state_t;

    typedef enum logic [2:0] {
        C_NONE   = 3'd0,
        C_OPI    = 3'd1,
        C_OP     = 3'd2,
        C_LOAD   = 3'd3,
        C_STORE  = 3'd4,
        C_BRANCH = 3'd5,
        C_JAL    = 3'd6,
        C_JALR   = 3'd7
    } cls_t;

    localparam logic [6:0] OPC_OPI    = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;

    state_t                 state_q, state_d;
    cls_t                   cls_q, cls_d;
    logic [TIMEOUT_W-1:0]   wait_q;
    logic [TIMEOUT_W:0]     wait_inc;
    logic                   timeout_hit;

    // The cycle that would bring the wait count up to TIMEOUT is the last
    // allowed waiting cycle; mem_ready in that cycle still completes.
    assign wait_inc    = {1'b0, wait_q} + 1'b1;
    assign timeout_hit = (TIMEOUT != 0) && (int'(wait_inc) == TIMEOUT);

    // State, class and wait-counter registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            cls_q   <= C_NONE;
            wait_q  <= '0;
        end else begin
            state_q <= state_d;
            cls_q   <= cls_d;
            // Staying in FETCH/MEM means the request is still waiting.
            if ((state_q == S_FETCH || state_q == S_MEM) && state_d == state_q)
                wait_q <= wait_inc[TIMEOUT_W-1:0];
            else
                wait_q <= '0;
        end
    end

    // Next-state and output decode from state plus registered class.
    always_comb begin
        state_d      = state_q;
        cls_d        = cls_q;
        mem_req      = 1'b0;
        mem_we       = 1'b0;
        mem_sel_data = 1'b0;
        ir_we        = 1'b0;
        pc_we        = 1'b0;
        pc_src       = 2'd0;
        alu_src_b    = 1'b0;
        alu_op       = 2'd0;
        rf_we        = 1'b0;
        wb_sel       = 2'd0;
        fault        = 1'b0;
        case (state_q)
            S_IDLE: state_d = S_FETCH;
            S_FETCH: begin
                mem_req = 1'b1;
                if (mem_ready) begin
                    ir_we   = 1'b1;
                    state_d = S_DECODE;
                end else if (timeout_hit) begin
                    state_d = S_FAULT;
                end
            end
            S_DECODE: begin
                state_d = S_EXEC;
                case (opcode)
                    OPC_OPI:    cls_d = C_OPI;
                    OPC_OP:     cls_d = C_OP;
                    OPC_LOAD:   cls_d = C_LOAD;
                    OPC_STORE:  cls_d = C_STORE;
                    OPC_BRANCH: cls_d = C_BRANCH;
                    OPC_JAL:    cls_d = C_JAL;
                    OPC_JALR:   cls_d = C_JALR;
                    default: begin
                        cls_d   = C_NONE;
                        state_d = S_FAULT;
                    end
                endcase
            end
            S_EXEC: begin
                case (cls_q)
                    C_OPI: begin
                        alu_src_b = 1'b1;
                        alu_op    = 2'd1;
                        state_d   = S_WB;
                    end
                    C_OP: begin
                        alu_op  = 2'd1;
                        state_d = S_WB;
                    end
                    C_LOAD, C_STORE: begin
                        alu_src_b = 1'b1;
                        state_d   = S_MEM;
                    end
                    C_BRANCH: begin
                        alu_op  = 2'd2;
                        pc_we   = 1'b1;
                        pc_src  = branch_taken ? 2'd1 : 2'd0;
                        state_d = S_FETCH;
                    end
                    C_JAL: begin
                        pc_we   = 1'b1;
                        pc_src  = 2'd1;
                        rf_we   = 1'b1;
                        wb_sel  = 2'd2;
                        state_d = S_FETCH;
                    end
                    C_JALR: begin
                        alu_src_b = 1'b1;
                        pc_we     = 1'b1;
                        pc_src    = 2'd2;
                        rf_we     = 1'b1;
                        wb_sel    = 2'd2;
                        state_d   = S_FETCH;
                    end
                    default: state_d = S_FAULT;
                endcase
            end
            S_MEM: begin
                mem_req      = 1'b1;
                mem_sel_data = 1'b1;
                mem_we       = (cls_q == C_STORE);
                if (mem_ready) begin
                    if (cls_q == C_STORE) begin
                        pc_we   = 1'b1;
                        state_d = S_FETCH;
                    end else begin
                        state_d = S_WB;
                    end
                end else if (timeout_hit) begin
                    state_d = S_FAULT;
                end
            end
            S_WB: begin
                rf_we   = 1'b1;
                wb_sel  = (cls_q == C_LOAD) ? 2'd1 : 2'd0;
                pc_we   = 1'b1;
                state_d = S_FETCH;
            end
            S_FAULT: fault = 1'b1;
            default: state_d = S_FAULT;
        endcase
    end

    assign state = state_q;

`ifdef MC_INSTRET_EN
    logic [31:0] instret_q;

    // Count instructions retiring back into FETCH; naturally frozen in FAULT.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            instret_q <= '0;
        else if (state_d == S_FETCH &&
                 (state_q == S_EXEC || state_q == S_MEM || state_q == S_WB))
            instret_q <= instret_q + 32'd1;
    end

    assign instret = instret_q;
`endif

endmodule

// File: tb/tb_mc_ctrl_fsm.sv
// Self-checking bench for mc_ctrl_fsm (TIMEOUT = 4).
module tb_mc_ctrl_fsm;

    localparam logic [6:0] OPI    = 7'b0010011;
    localparam logic [6:0] OP     = 7'b0110011;
    localparam logic [6:0] LOAD   = 7'b0000011;
    localparam logic [6:0] STORE  = 7'b0100011;
    localparam logic [6:0] BRANCH = 7'b1100011;
    localparam logic [6:0] JAL    = 7'b1101111;
    localparam logic [6:0] JALR   = 7'b1100111;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [6:0] opcode = 7'd0;
    logic       branch_taken = 1'b0;
    logic       mem_ready = 1'b0;
    logic       mem_req, mem_we, mem_sel_data, ir_we, pc_we, rf_we, alu_src_b, fault;
    logic [1:0] pc_src, alu_op, wb_sel;
    logic [2:0] state;
`ifdef MC_INSTRET_EN
    logic [31:0] instret;
`endif

    int total = 0;
    int bad = 0;
    int exp_instret = 0;

    // results of one run_instr call
    int r_cyc, r_end, r_pcwe, r_rfwe, r_pcsrc, r_wbsel, r_dreq, r_dwe, r_freq, r_irwe;
    int r_aluop, r_alusrcb, r_pcwe_st, r_rfwe_st;
    int r_seq[$];

    typedef struct {
        int lat; int rfwe; int pcsrc; int wbsel; int dreq; int dwe; int aluop; int srcb;
    } exp_t;

    always #5 clk = ~clk;

    mc_ctrl_fsm #(.TIMEOUT(4), .TIMEOUT_W(3)) dut (
        .clk(clk), .rst_n(rst_n), .opcode(opcode), .branch_taken(branch_taken),
        .mem_ready(mem_ready), .mem_req(mem_req), .mem_we(mem_we),
        .mem_sel_data(mem_sel_data), .ir_we(ir_we), .pc_we(pc_we), .pc_src(pc_src),
        .alu_src_b(alu_src_b), .alu_op(alu_op), .rf_we(rf_we), .wb_sel(wb_sel),
        .fault(fault), .state(state)
`ifdef MC_INSTRET_EN
        , .instret(instret)
`endif
    );

    // Transaction-level expectations for one instruction, from the class
    // rules: latency, write-strobe counts, selects and data-access cycles.
    function automatic exp_t model(input logic [6:0] op, input logic tk, input int df, input int dm);
        exp_t e;
        e = '{lat: 4, rfwe: 1, pcsrc: 0, wbsel: 0, dreq: 0, dwe: 0, aluop: 0, srcb: -1};
        case (op)
            OPI:    begin e.aluop = 1; e.srcb = 1; end
            OP:     begin e.aluop = 1; e.srcb = 0; end
            LOAD:   begin e.lat = 5 + dm; e.wbsel = 1; e.dreq = dm + 1; e.srcb = 1; end
            STORE:  begin e.lat = 4 + dm; e.rfwe = 0; e.wbsel = -1; e.dreq = dm + 1;
                          e.dwe = dm + 1; e.srcb = 1; end
            BRANCH: begin e.lat = 3; e.rfwe = 0; e.wbsel = -1; e.pcsrc = tk ? 1 : 0; e.aluop = 2; end
            JAL:    begin e.lat = 3; e.pcsrc = 1; e.wbsel = 2; end
            JALR:   begin e.lat = 3; e.pcsrc = 2; e.wbsel = 2; e.srcb = 1; end
            default: ;
        endcase
        e.lat = e.lat + df;
        return e;
    endfunction

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        exp_instret = 0;
        @(negedge clk);
    endtask

    // Runs one instruction starting in FETCH, acting as a memory that
    // answers after df (fetch) / dm (data) wait cycles. Ends at a negedge
    // back in FETCH (r_end=1), in FAULT (r_end=2) or on budget (r_end=0).
    task automatic run_instr(input logic [6:0] op, input logic tk, input int df, input int dm);
        int waited;
        bit left;
        waited = 0; left = 0;
        r_cyc = 0; r_end = 0; r_pcwe = 0; r_rfwe = 0; r_pcsrc = -1; r_wbsel = -1;
        r_dreq = 0; r_dwe = 0; r_freq = 0; r_irwe = 0; r_aluop = -1; r_alusrcb = -1;
        r_pcwe_st = -1; r_rfwe_st = -1;
        r_seq.delete();
        opcode = op;
        branch_taken = tk;
        while (r_cyc < 60) begin
            if (mem_req) mem_ready = (waited == (mem_sel_data ? dm : df));
            else         mem_ready = 1'($urandom_range(0, 1));
            #1;
            r_seq.push_back(int'(state));
            r_cyc++;
            if (state == 3'd3) begin r_aluop = int'(alu_op); r_alusrcb = int'(alu_src_b); end
            if (pc_we) begin r_pcwe++; r_pcsrc = int'(pc_src); r_pcwe_st = int'(state); end
            if (rf_we) begin r_rfwe++; r_wbsel = int'(wb_sel); r_rfwe_st = int'(state); end
            if (ir_we) r_irwe++;
            if (mem_req && !mem_sel_data) r_freq++;
            if (mem_req && mem_sel_data) r_dreq++;
            if (mem_req && mem_we) r_dwe++;
            if (state != 3'd1) left = 1;
            if (mem_req) waited = mem_ready ? 0 : waited + 1;
            @(negedge clk);
            if (state == 3'd6) begin r_end = 2; break; end
            if (left && state == 3'd1) begin r_end = 1; exp_instret++; break; end
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        mem_ready = 1'b1;
        repeat (2) @(negedge clk);
        #1;
        total++;
        if ({mem_req, mem_we, mem_sel_data, ir_we, pc_we, pc_src, alu_src_b, alu_op,
             rf_we, wb_sel, fault, state} !== 18'd0) begin
            bad++;
            $display("FAIL reset_outputs: got state=%0d req=%0b pc_we=%0b rf_we=%0b want all 0",
                     state, mem_req, pc_we, rf_we);
        end
        @(negedge clk);
        rst_n = 1'b1;
        total++;
        if (state !== 3'd0 || mem_req !== 1'b0) begin
            bad++;
            $display("FAIL reset_idle: got state=%0d req=%0b want 0 0", state, mem_req);
        end
        @(negedge clk);
        total++;
        if (state !== 3'd1) begin
            bad++;
            $display("FAIL idle_to_fetch: got state=%0d want 1", state);
        end
`ifdef MC_INSTRET_EN
        total++;
        if (instret !== 32'd0) begin
            bad++;
            $display("FAIL instret_reset: got %0d want 0", instret);
        end
`endif
    endtask

    task automatic test_addi();
        int want[4] = '{1, 2, 3, 5};
        bit ok;
        run_instr(OPI, 1'b0, 0, 0);
        ok = (r_seq.size() == 4) && (r_end == 1);
        for (int i = 0; i < 4 && ok; i++) if (r_seq[i] != want[i]) ok = 0;
        total++;
        if (!ok) begin
            bad++;
            $display("FAIL addi_seq: got len=%0d end=%0d want states 1,2,3,5 then 1", r_seq.size(), r_end);
        end
        total++;
        if (r_rfwe != 1 || r_rfwe_st != 5 || r_wbsel != 0) begin
            bad++;
            $display("FAIL addi_rfwe: got cnt=%0d st=%0d wb=%0d want 1 5 0", r_rfwe, r_rfwe_st, r_wbsel);
        end
        total++;
        if (r_pcwe != 1 || r_pcwe_st != 5 || r_pcsrc != 0) begin
            bad++;
            $display("FAIL addi_pcwe: got cnt=%0d st=%0d src=%0d want 1 5 0", r_pcwe, r_pcwe_st, r_pcsrc);
        end
    endtask

    task automatic test_load_delay();
        run_instr(LOAD, 1'b0, 0, 3);
        total++;
        if (r_dreq != 4 || r_dwe != 0) begin
            bad++;
            $display("FAIL load_req: got req=%0d we=%0d want 4 0", r_dreq, r_dwe);
        end
        total++;
        if (r_wbsel != 1 || r_rfwe_st != 5 || r_cyc != 8) begin
            bad++;
            $display("FAIL load_wb: got wb=%0d st=%0d lat=%0d want 1 5 8", r_wbsel, r_rfwe_st, r_cyc);
        end
    endtask

    task automatic test_branch();
        for (int t = 1; t >= 0; t--) begin
            run_instr(BRANCH, 1'(t), 0, 0);
            total++;
            if (r_pcsrc != t || r_pcwe_st != 3 || r_rfwe != 0 || r_cyc != 3 || r_end != 1) begin
                bad++;
                $display("FAIL branch_t%0d: got src=%0d st=%0d rf=%0d lat=%0d want %0d 3 0 3",
                         t, r_pcsrc, r_pcwe_st, r_rfwe, r_cyc, t);
            end
        end
    endtask

    task automatic test_jalr();
        run_instr(JALR, 1'b0, 0, 0);
        total++;
        if (r_pcsrc != 2 || r_wbsel != 2 || r_pcwe != 1 || r_rfwe != 1 ||
            r_pcwe_st != 3 || r_rfwe_st != 3) begin
            bad++;
            $display("FAIL jalr_exec: got src=%0d wb=%0d pcst=%0d rfst=%0d want 2 2 3 3",
                     r_pcsrc, r_wbsel, r_pcwe_st, r_rfwe_st);
        end
    endtask

    task automatic test_random();
        logic [6:0] ops[7];
        exp_t e;
        logic [6:0] op;
        logic tk;
        int df, dm;
        ops = '{OPI, OP, LOAD, STORE, BRANCH, JAL, JALR};
        for (int n = 0; n < 60; n++) begin
            op = ops[$urandom_range(0, 6)];
            tk = 1'($urandom_range(0, 1));
            df = $urandom_range(0, 3);
            dm = $urandom_range(0, 3);
            e = model(op, tk, df, dm);
            run_instr(op, tk, df, dm);
            total++;
            if (r_end != 1 || r_cyc != e.lat) begin
                bad++;
                $display("FAIL rnd%0d_latency op=%b: got %0d end=%0d want %0d", n, op, r_cyc, r_end, e.lat);
            end
            total++;
            if (r_pcwe != 1 || r_pcsrc != e.pcsrc || r_irwe != 1 || r_freq != df + 1) begin
                bad++;
                $display("FAIL rnd%0d_pc op=%b: got pcwe=%0d src=%0d ir=%0d freq=%0d want 1 %0d 1 %0d",
                         n, op, r_pcwe, r_pcsrc, r_irwe, r_freq, e.pcsrc, df + 1);
            end
            total++;
            if (r_rfwe != e.rfwe || r_wbsel != e.wbsel) begin
                bad++;
                $display("FAIL rnd%0d_rf op=%b: got rfwe=%0d wb=%0d want %0d %0d",
                         n, op, r_rfwe, r_wbsel, e.rfwe, e.wbsel);
            end
            total++;
            if (r_dreq != e.dreq || r_dwe != e.dwe || r_aluop != e.aluop ||
                (e.srcb >= 0 && r_alusrcb != e.srcb)) begin
                bad++;
                $display("FAIL rnd%0d_exec op=%b: got dreq=%0d dwe=%0d aluop=%0d srcb=%0d want %0d %0d %0d %0d",
                         n, op, r_dreq, r_dwe, r_aluop, r_alusrcb, e.dreq, e.dwe, e.aluop, e.srcb);
            end
        end
`ifdef MC_INSTRET_EN
        total++;
        if (instret !== 32'(exp_instret)) begin
            bad++;
            $display("FAIL instret_random: got %0d want %0d", instret, exp_instret);
        end
`endif
    endtask

    task automatic test_bad_opcode();
        bit ok;
        run_instr(7'b0000000, 1'b0, 0, 0);
        total++;
        if (r_end != 2 || r_cyc != 2) begin
            bad++;
            $display("FAIL badop_fault: got end=%0d cyc=%0d want 2 2", r_end, r_cyc);
        end
        ok = 1;
        for (int i = 0; i < 8; i++) begin
            mem_ready = 1'($urandom_range(0, 1));
            #1;
            if (fault !== 1'b1 || state !== 3'd6 || mem_req || ir_we || pc_we || rf_we) ok = 0;
            @(negedge clk);
        end
        total++;
        if (!ok) begin
            bad++;
            $display("FAIL badop_sticky: got fault=%0b state=%0d req=%0b want 1 6 0", fault, state, mem_req);
        end
`ifdef MC_INSTRET_EN
        total++;
        if (instret !== 32'(exp_instret)) begin
            bad++;
            $display("FAIL instret_frozen: got %0d want %0d", instret, exp_instret);
        end
`endif
    endtask

    task automatic test_timeout();
        do_reset();
        run_instr(OPI, 1'b0, 100, 0);
        total++;
        if (r_end != 2 || r_freq != 4 || r_cyc != 4) begin
            bad++;
            $display("FAIL fetch_timeout: got end=%0d waits=%0d want 2 4", r_end, r_freq);
        end
        do_reset();
        run_instr(LOAD, 1'b0, 0, 100);
        total++;
        if (r_end != 2 || r_dreq != 4) begin
            bad++;
            $display("FAIL mem_timeout: got end=%0d waits=%0d want 2 4", r_end, r_dreq);
        end
        do_reset();
        run_instr(OP, 1'b0, 3, 0);
        total++;
        if (r_end != 1 || r_cyc != 7) begin
            bad++;
            $display("FAIL ready_at_timeout: got end=%0d lat=%0d want 1 7", r_end, r_cyc);
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        opcode = STORE;
        for (int i = 0; i < 10 && state != 3'd4; i++) begin
            mem_ready = mem_req;
            @(negedge clk);
        end
        mem_ready = 1'b0;
        #1;
        total++;
        if (state !== 3'd4 || mem_req !== 1'b1 || mem_we !== 1'b1) begin
            bad++;
            $display("FAIL mid_reach_mem: got state=%0d req=%0b we=%0b want 4 1 1", state, mem_req, mem_we);
        end
        #1 rst_n = 1'b0;
        #1;
        total++;
        if (mem_req !== 1'b0 || state !== 3'd0 || pc_we !== 1'b0 || rf_we !== 1'b0) begin
            bad++;
            $display("FAIL mid_reset: got req=%0b state=%0d want 0 0", mem_req, state);
        end
        @(negedge clk);
        rst_n = 1'b1;
        exp_instret = 0;
        @(negedge clk);
    endtask

    task automatic test_back_to_back();
        run_instr(OPI, 1'b0, 0, 0);
        run_instr(STORE, 1'b0, 0, 0);
        total++;
        if (r_end != 1 || r_cyc != 4 || r_pcwe_st != 4 || r_rfwe != 0) begin
            bad++;
            $display("FAIL b2b_store: got end=%0d lat=%0d pcst=%0d rf=%0d want 1 4 4 0",
                     r_end, r_cyc, r_pcwe_st, r_rfwe);
        end
        run_instr(JAL, 1'b0, 0, 0);
        total++;
        if (r_cyc != 3 || r_pcsrc != 1 || r_wbsel != 2) begin
            bad++;
            $display("FAIL b2b_jal: got lat=%0d src=%0d wb=%0d want 3 1 2", r_cyc, r_pcsrc, r_wbsel);
        end
`ifdef MC_INSTRET_EN
        total++;
        if (instret !== 32'd3) begin
            bad++;
            $display("FAIL instret_three: got %0d want 3", instret);
        end
`endif
    endtask

    initial begin
        test_reset();
        test_addi();
        test_load_delay();
        test_branch();
        test_jalr();
        test_random();
        test_bad_opcode();
        test_timeout();
        test_reset_mid();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got no finish want finish before 500us");
        $fatal(1);
    end

endmodule

// File: doc/mc_ctrl_fsm.md
Name: mc_ctrl_fsm

Overview:
- Multicycle control FSM for the RV32I datapath: PC, instruction register, register file, immediate generator, ALU, and one shared single-port memory.
- Sequences each instruction through FETCH/DECODE/EXEC/MEM/WB and drives all datapath strobes and mux selects.
- Talks to the memory over a req/ready handshake.
- Traps on unsupported opcodes and on memory timeouts.

Parameters:
- TIMEOUT, 255: maximum cycles mem_req may wait without mem_ready before entering FAULT; 0 disables the timeout.
- TIMEOUT_W, 8: width of the internal wait counter; must satisfy TIMEOUT < 2^TIMEOUT_W.

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- opcode  in  7  instr[6:0] from instruction register
- branch_taken  in  1  ALU compare result, valid in EXEC
- mem_ready  in  1  memory completes the access this cycle
- mem_req  out  1  memory access request
- mem_we  out  1  1 = store
- mem_sel_data  out  1  0 = address from PC, 1 = address from ALU
- ir_we  out  1  capture instruction register
- pc_we  out  1  update PC
- pc_src  out  2  0 = PC+4, 1 = PC+imm, 2 = {alu_out[31:1],1'b0}
- alu_src_b  out  1  0 = rs2, 1 = imm
- alu_op  out  2  0 = add, 1 = funct-decoded, 2 = compare
- rf_we  out  1  register file write enable
- wb_sel  out  2  0 = ALU, 1 = memory data, 2 = PC+4
- fault  out  1  sticky trap flag
- state  out  3  current state, for debug

Behaviour:
- States and encodings: IDLE = 0, FETCH = 1, DECODE = 2, EXEC = 3, MEM = 4, WB = 5, FAULT = 6.
- Reset: asynchronous; rst_n low forces state = IDLE, fault = 0, wait counter = 0, class register cleared. All outputs are 0 during and after reset; outputs are a combinational decode of state plus the registered class.
- Reset mid-operation (including mid-handshake) drops mem_req immediately. No partial PC or register-file write may occur.
- IDLE: 1 cycle, then FETCH.
- FETCH:
  - Drives mem_req = 1, mem_sel_data = 0.
  - On mem_ready: ir_we = 1 in the same cycle, then DECODE.
  - Otherwise stay in FETCH.
- DECODE (1 cycle): classify opcode into the class register.
  - 0010011 OPI, 0110011 OP, 0000011 LOAD, 0100011 STORE, 1100011 BRANCH, 1101111 JAL, 1100111 JALR.
  - Any other opcode: go to FAULT.
- EXEC (1 cycle):
  - OPI: alu_src_b = 1, alu_op = 1, then WB.
  - OP: alu_src_b = 0, alu_op = 1, then WB.
  - LOAD/STORE: alu_src_b = 1, alu_op = 0, then MEM.
  - BRANCH: alu_op = 2, pc_we = 1, pc_src = branch_taken ? 1 : 0, then FETCH.
  - JAL: pc_we = 1, pc_src = 1, rf_we = 1, wb_sel = 2, then FETCH.
  - JALR: alu_src_b = 1, alu_op = 0, pc_we = 1, pc_src = 2, rf_we = 1, wb_sel = 2, then FETCH.
- MEM:
  - Drives mem_req = 1, mem_sel_data = 1, mem_we = (class == STORE).
  - On mem_ready, STORE: pc_we = 1, pc_src = 0, then FETCH.
  - On mem_ready, LOAD: go to WB.
- WB (1 cycle): rf_we = 1, wb_sel = (LOAD ? 1 : 0), pc_we = 1, pc_src = 0, then FETCH.
- Instruction latency with a zero-wait memory (mem_ready in the first request cycle):
  - BRANCH/JAL/JALR: 3 cycles.
  - OPI/OP/STORE: 4 cycles.
  - LOAD: 5 cycles.
- mem_req, once asserted, stays high until mem_ready. mem_ready outside FETCH/MEM is ignored.
- Wait counter:
  - Cleared on entry to FETCH or MEM.
  - Increments each cycle mem_req = 1 and mem_ready = 0.
  - When it reaches TIMEOUT (with TIMEOUT != 0) and mem_ready = 0: go to FAULT.
  - mem_ready arriving in the same cycle as the timeout wins; the access completes normally.
- FAULT:
  - fault = 1; all strobes (mem_req, ir_we, pc_we, rf_we) are 0.
  - Left only by reset.
- pc_we and rf_we are each asserted for exactly one cycle per instruction; rf_we never asserts for STORE or BRANCH.

Optional Feature:
- Macro: MC_INSTRET_EN.
- When defined:
  - Adds output instret (out, 32): count of retired instructions.
  - Increments on every transition into FETCH from EXEC, MEM or WB.
  - Reset value 0; wraps 0xFFFFFFFF -> 0; frozen in FAULT.
- When undefined: the port and the counter are absent; all other behaviour is identical.

Test Plan:
- Reset then zero-wait memory, fetch ADDI (0010011) -> state sequence 0,1,2,3,5,1; rf_we = 1 only in WB; pc_we with pc_src = 0 in WB.
- LOAD with mem_ready delayed 3 cycles in MEM -> mem_req held high for 4 cycles, mem_we = 0; WB has wb_sel = 1.
- BRANCH with branch_taken = 1, then with 0 -> EXEC drives pc_src = 1, then 0; rf_we = 0; returns to FETCH after 3 cycles.
- JALR -> EXEC: pc_src = 2, wb_sel = 2, rf_we = 1, pc_we = 1 in a single cycle.
- Opcode 0000000 -> FAULT after DECODE, fault = 1, no further mem_req. TIMEOUT = 4 with mem_ready held low -> FAULT after 4 waiting cycles.
- Assert rst_n low during MEM with mem_req = 1 -> mem_req drops without waiting for a clock; state = 0. With MC_INSTRET_EN, instret = 3 after three completed instructions.
